// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// The CSUM state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_FIN,
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus imem write port of the loader.
// slave = loader side, master = byte source / imem side.
interface imem_loader_if #(parameter int ADDR_W = 8);
  import imem_loader_pkg::*;

  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [WORD_W-1:0] imem_wdata;

  modport slave  (input  byte_in, byte_valid,
                  output byte_ready, imem_we, imem_waddr, imem_wdata);
  modport master (output byte_in, byte_valid,
                  input  byte_ready, imem_we, imem_waddr, imem_wdata);

endinterface

// File: rtl/imem_loader_word_packer.sv
// Assembles little-endian 32-bit words from accepted bytes; flags the
// completing (4th) byte combinationally so the top can register the write.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              take_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              wordComplete_o
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] low_q, low_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q <= '0;
      low_q  <= '0;
    end else begin
      lane_q <= lane_d;
      low_q  <= low_d;
    end
  end

  always_comb begin
    lane_d = lane_q;
    low_d  = low_q;
    if (clear_i) begin
      lane_d = '0;
      low_d  = '0;
    end else if (take_i) begin
      lane_d = lane_q + 2'd1;
      case (lane_q)
        2'd0:    low_d[7:0]   = byte_i;
        2'd1:    low_d[15:8]  = byte_i;
        2'd2:    low_d[23:16] = byte_i;
        default: low_d        = low_q;
      endcase
    end
  end

  // Upper lane comes straight from the bus so the word is ready on the 4th byte.
  assign word_o         = {byte_i, low_q};
  assign wordComplete_o = take_i && !clear_i && (lane_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Program loader: header word count, payload words to imem, core hold control.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          core_hold,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int unsigned CAPACITY = 32'd1 << ADDR_W;

  state_e            state_q, state_d;
  logic [7:0]        hdrLow_q, hdrLow_d;
  logic              hdrIdx_q, hdrIdx_d;
  logic [15:0]       wordTotal_q, wordTotal_d;
  logic [15:0]       wordCnt_q, wordCnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              byteReady;
  logic              accept;
  logic              startOk;
  logic [15:0]       hdrWord;
  logic [WORD_W-1:0] packedWord;
  logic              wordComplete;

  assign byteReady = (state_q == ST_HDR) || (state_q == ST_LOAD)
`ifdef IMEM_LOADER_CHECKSUM_EN
                     || (state_q == ST_CSUM)
`endif
                     ;
  assign accept  = bus.byte_valid && byteReady;
  assign startOk = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                             (state_q == ST_ERROR));
  assign hdrWord = {bus.byte_in, hdrLow_q};

  word_packer u_packer (
    .clk            (clk),
    .reset          (reset),
    .clear_i        (startOk),
    .take_i         (accept && (state_q == ST_LOAD)),
    .byte_i         (bus.byte_in),
    .word_o         (packedWord),
    .wordComplete_o (wordComplete)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hdrLow_q    <= '0;
      hdrIdx_q    <= 1'b0;
      wordTotal_q <= '0;
      wordCnt_q   <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hdrLow_q    <= hdrLow_d;
      hdrIdx_q    <= hdrIdx_d;
      wordTotal_q <= wordTotal_d;
      wordCnt_q   <= wordCnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    hdrLow_d    = hdrLow_q;
    hdrIdx_d    = hdrIdx_q;
    wordTotal_d = wordTotal_q;
    wordCnt_d   = wordCnt_q;
    addr_d      = addr_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d   = ST_HDR;
          hdrIdx_d  = 1'b0;
          wordCnt_d = '0;
          addr_d    = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d    = '0;
`endif
        end
      end
      ST_HDR: begin
        if (accept) begin
          if (hdrIdx_q != 1'(HDR_BYTES - 1)) begin
            hdrLow_d = bus.byte_in;
            hdrIdx_d = 1'b1;
          end else begin
            wordTotal_d = hdrWord;
            if ((hdrWord == 16'd0) || (32'(hdrWord) > CAPACITY)) state_d = ST_ERROR;
            else                                                  state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) csum_d = csum_q ^ bus.byte_in;
`endif
        if (wordComplete) begin
          we_d      = 1'b1;
          waddr_d   = addr_q;
          wdata_d   = packedWord;
          addr_d    = addr_q + 1'b1;
          wordCnt_d = wordCnt_q + 16'd1;
          if (wordCnt_q == wordTotal_q - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_FIN;
`endif
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) state_d = (bus.byte_in == csum_q) ? ST_FIN : ST_ERROR;
      end
`endif
      // FIN lets the final write pulse retire before the core is released.
      ST_FIN:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.byte_ready = byteReady;
  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;

  assign busy      = byteReady || (state_q == ST_FIN);
  assign core_hold = busy || (state_q == ST_ERROR);
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader (ADDR_W = 4) against a
// transaction-level model; honours IMEM_LOADER_CHECKSUM_EN when defined.
module tb_imem_loader;

  localparam int AW = 4;
  localparam int CAP = 1 << AW;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef enum int {P_IDLE, P_HDR, P_LOAD, P_CSUM, P_FIN, P_DONE, P_ERR} phase_e;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic core_hold, busy, done, error;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus.slave),
    .core_hold (core_hold),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  // Behavioural model state
  phase_e      mPhase = P_IDLE;
  int          mHdrCnt = 0;
  logic [15:0] mN = '0;
  int          mBytes = 0;
  logic [7:0]  mXor = '0;
  logic [31:0] mWord = '0;
  logic        mWe = 1'b0;
  int          mAddr = 0;
  logic [31:0] mData = '0;
  logic [31:0] mMem [0:CAP-1];

  // Captured DUT writes
  logic [31:0] dutMem [0:CAP-1];
  int          weCount = 0;
  int          lastAddr = -1;

  logic [7:0]  stim [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    if (reset) begin
      mPhase = P_IDLE; mWe = 1'b0; mAddr = 0; mData = '0;
      mHdrCnt = 0; mBytes = 0; mXor = '0;
    end else begin
      mWe = 1'b0;
      case (mPhase)
        P_IDLE, P_DONE, P_ERR:
          if (start) begin
            mPhase = P_HDR; mHdrCnt = 0; mBytes = 0; mXor = '0;
          end
        P_HDR:
          if (bus.byte_valid) begin
            if (mHdrCnt == 0) begin
              mN[7:0] = bus.byte_in; mHdrCnt = 1;
            end else begin
              mN[15:8] = bus.byte_in;
              mPhase = (mN == 0 || int'(mN) > CAP) ? P_ERR : P_LOAD;
            end
          end
        P_LOAD:
          if (bus.byte_valid) begin
            mWord[8*(mBytes%4) +: 8] = bus.byte_in;
            mXor = mXor ^ bus.byte_in;
            mBytes++;
            if (mBytes % 4 == 0) begin
              mWe = 1'b1; mAddr = mBytes/4 - 1; mData = mWord; mMem[mAddr] = mWord;
            end
            if (mBytes == 4*int'(mN)) mPhase = CSUM_EN ? P_CSUM : P_FIN;
          end
        P_CSUM:
          if (bus.byte_valid) mPhase = (bus.byte_in == mXor) ? P_FIN : P_ERR;
        P_FIN:   mPhase = P_DONE;
        default: mPhase = P_IDLE;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    modelStep();
  end

  // Compare every cycle on the falling edge; also record DUT writes.
  initial forever begin
    @(negedge clk);
    checkOutput("byte_ready", 32'(bus.byte_ready), 32'(mPhase inside {P_HDR, P_LOAD, P_CSUM}));
    checkOutput("busy",       32'(busy),           32'(mPhase inside {P_HDR, P_LOAD, P_CSUM, P_FIN}));
    checkOutput("core_hold",  32'(core_hold),      32'(mPhase inside {P_HDR, P_LOAD, P_CSUM, P_FIN, P_ERR}));
    checkOutput("done",       32'(done),           32'(mPhase == P_DONE));
    checkOutput("error",      32'(error),          32'(mPhase == P_ERR));
    checkOutput("imem_we",    32'(bus.imem_we),    32'(mWe));
    checkOutput("imem_waddr", 32'(bus.imem_waddr), 32'(mAddr));
    checkOutput("imem_wdata", bus.imem_wdata,      mData);
    if (bus.imem_we === 1'b1) begin
      dutMem[bus.imem_waddr] = bus.imem_wdata;
      weCount++;
      lastAddr = int'(bus.imem_waddr);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    bit got;
    bus.byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.byte_valid = 1'b1;
    bus.byte_in = b;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = bus.byte_ready;
      @(posedge clk); #1;
    end
    bus.byte_valid = 1'b0;
    if (!got) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  // Sends the whole stim queue; returns one cycle after the last byte was accepted.
  task automatic applyStimulus(input int gapMin, input int gapMax);
    foreach (stim[i]) sendByte(stim[i], int'($urandom_range(gapMax, gapMin)));
  endtask

  task automatic buildImage(input int n, input bit badCsum);
    logic [7:0] b, x;
    logic [15:0] nw;
    nw = 16'(n);
    x = '0;
    stim.delete();
    stim.push_back(nw[7:0]);
    stim.push_back(nw[15:8]);
    for (int i = 0; i < 4*n; i++) begin
      b = 8'($urandom);
      x = x ^ b;
      stim.push_back(b);
    end
    if (CSUM_EN) stim.push_back(badCsum ? (x ^ 8'h01) : x);
  endtask

  task automatic waitEnd(input string name, input bit expDone);
    bit ended;
    ended = 1'b0;
    for (int c = 0; c < 10 && !ended; c++) begin
      @(negedge clk);
      ended = done || error;
    end
    checkOutput(name, 32'(done), 32'(expDone));
  endtask

  initial begin
    int w0;
    bus.byte_valid = 1'b0;
    bus.byte_in = '0;
    foreach (mMem[i]) begin mMem[i] = '0; dutMem[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_core_hold", 32'(core_hold), 32'd0);
    checkOutput("reset_we", 32'(bus.imem_we), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] two-word fixed image");
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    if (CSUM_EN) stim.push_back(8'h90);
    w0 = weCount;
    pulseStart();
    applyStimulus(0, 0);
    if (!CSUM_EN) begin
      checkOutput("fixed_we_k1", 32'(bus.imem_we), 32'd1);
      checkOutput("fixed_waddr_k1", 32'(bus.imem_waddr), 32'd1);
    end
    @(posedge clk); #1;
    checkOutput("fixed_done_k2", 32'(done), 32'd1);
    checkOutput("fixed_hold_k2", 32'(core_hold), 32'd0);
    checkOutput("fixed_dut_mem0", dutMem[0], 32'h0000_0013);
    checkOutput("fixed_dut_mem1", dutMem[1], 32'h0010_0093);
    checkOutput("fixed_model_mem1", mMem[1], 32'h0010_0093);
    checkOutput("fixed_we_count", 32'(weCount - w0), 32'd2);

    $display("[TB] zero-length header");
    stim = '{8'h00, 8'h00};
    w0 = weCount;
    pulseStart();
    applyStimulus(0, 0);
    checkOutput("zero_error", 32'(error), 32'd1);
    checkOutput("zero_hold", 32'(core_hold), 32'd1);
    checkOutput("zero_ready", 32'(bus.byte_ready), 32'd0);
    repeat (2) @(posedge clk); #1;
    checkOutput("zero_no_we", 32'(weCount - w0), 32'd0);
    buildImage(3, 1'b0);
    pulseStart();
    applyStimulus(0, 2);
    waitEnd("recover_done", 1'b1);

    $display("[TB] capacity boundary");
    stim = '{8'h11, 8'h00};
    pulseStart();
    applyStimulus(0, 0);
    checkOutput("over_cap_error", 32'(error), 32'd1);
    buildImage(CAP, 1'b0);
    pulseStart();
    applyStimulus(0, 1);
    waitEnd("full_done", 1'b1);
    checkOutput("full_last_addr", 32'(lastAddr), 32'(CAP - 1));

    $display("[TB] valid every third cycle");
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    if (CSUM_EN) stim.push_back(8'h90);
    w0 = weCount;
    dutMem[0] = '0; dutMem[1] = '0;
    pulseStart();
    applyStimulus(2, 2);
    waitEnd("slow_done", 1'b1);
    checkOutput("slow_we_count", 32'(weCount - w0), 32'd2);
    checkOutput("slow_dut_mem0", dutMem[0], 32'h0000_0013);
    checkOutput("slow_dut_mem1", dutMem[1], 32'h0010_0093);

    $display("[TB] reset mid-load");
    stim = '{8'h02, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h55, 8'h66};
    w0 = weCount;
    pulseStart();
    applyStimulus(0, 1);
    reset = 1'b1;
    #1;
    checkOutput("rst_hold", 32'(core_hold), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(bus.byte_ready), 32'd0);
    checkOutput("rst_we", 32'(bus.imem_we), 32'd0);
    checkOutput("rst_waddr", 32'(bus.imem_waddr), 32'd0);
    checkOutput("rst_wdata", bus.imem_wdata, 32'd0);
    checkOutput("rst_done_err", {30'd0, done, error}, 32'd0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk); #1;
    checkOutput("rst_we_count", 32'(weCount - w0), 32'd1);
    checkOutput("rst_last_addr", 32'(lastAddr), 32'd0);
    checkOutput("rst_word0", dutMem[0], 32'hD4C3_B2A1);

    $display("[TB] random images");
    for (int t = 0; t < 8; t++) begin
      bit bad;
      bad = CSUM_EN && (t % 3 == 2);
      buildImage(int'($urandom_range(CAP, 1)), bad);
      pulseStart();
      if (t == 3) begin
        start = 1'b1;
        sendByte(stim[0], 0);
        start = 1'b0;
        stim.delete(0);
      end
      applyStimulus(0, 2);
      if (bad) begin
        checkOutput("csum_bad_error", 32'(error), 32'd1);
        checkOutput("csum_bad_done", 32'(done), 32'd0);
        checkOutput("csum_bad_hold", 32'(core_hold), 32'd1);
      end
      waitEnd("rand_end", !bad);
      bus.byte_in = 8'($urandom);
      bus.byte_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus.byte_valid = 1'b0;
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader: the write side of the instruction memory that `instruction_fetch` reads. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and drives the instruction-memory write port from word address 0 upward. It holds the core in reset (`core_hold`) while loading and releases it once the image is complete. It sits between the host/debug byte source and the imem write port, alongside the fetch path.

## Interface
Parameters:
- `ADDR_W`, 8, imem word-address width; capacity 2**ADDR_W words.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a load; honoured in IDLE, DONE and ERROR only.
- `byte_in`  in  8  stream data.
- `byte_valid`  in  1  `byte_in` valid.
- `byte_ready`  out  1  loader accepts a byte; transfer occurs when `byte_valid & byte_ready`.
- `imem_we`  out  1  imem write strobe, one-cycle pulse per word.
- `imem_waddr`  out  ADDR_W  imem word address.
- `imem_wdata`  out  32  imem write data.
- `core_hold`  out  1  holds fetch/PC in reset while high.
- `busy`  out  1  load in progress (HDR, LOAD, CSUM, FIN).
- `done`  out  1  image loaded; level, held until next `start` or reset.
- `error`  out  1  load aborted; level, held until next `start` or reset.

## Operation
- States: IDLE, HDR, LOAD, CSUM (macro only), FIN, DONE, ERROR.
- IDLE/DONE/ERROR + `start` → HDR. Clears `done`, `error`, the word counter, the address and the byte lane index. `start` in other states is ignored.
- HDR: accepts 2 bytes, forming a 16-bit word count N (little-endian).
  - N == 0 or N > 2**ADDR_W → ERROR.
  - Otherwise → LOAD.
- LOAD: bytes fill lanes 0..3 (lane 0 = bits 7:0).
  - On the 4th byte, register `imem_wdata`, `imem_waddr` = word index and `imem_we` = 1 for the next cycle.
  - The address increments after each write. Lane index wraps to 0.
  - After word N-1, go to CSUM (macro) or FIN.
- FIN: one cycle, guaranteeing the last write has completed. Then → DONE.
- `byte_ready` = 1 in HDR, LOAD and CSUM; 0 elsewhere. The stream is never stalled by the write pulse: a byte can be accepted in the same cycle `imem_we` is high.
- `core_hold` = 1 in HDR, LOAD, CSUM, FIN and ERROR; 0 in IDLE and DONE.
- Extra bytes arriving after the last expected byte are not accepted (`byte_ready` = 0).

## Timing
- Reset (async, any state): state IDLE. All outputs 0, including `core_hold`, `imem_we`, `imem_waddr`, `imem_wdata`, `done` and `error`. Partial words are discarded. Words already written remain in imem.
- Word write latency: 4th byte accepted in cycle k → `imem_we` high in cycle k+1 only.
- Final word (no macro): byte at cycle k → write in k+1 (FIN) → `done` = 1, `core_hold` = 0 in k+2.
- `byte_valid` may drop between bytes; the lane index and counters hold.
- Header error: 2nd header byte accepted in cycle k → `error` = 1, `byte_ready` = 0 in k+1.
- Boundary: N = 2**ADDR_W is legal. `imem_waddr` reaches 2**ADDR_W-1 and does not wrap before DONE.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: after the final word, CSUM accepts one byte. That byte must equal the XOR of all 4N payload bytes (header excluded).
  - Checksum byte accepted in cycle j → match: FIN in j+1, DONE in j+2.
  - Mismatch: ERROR in j+1.
  - Imem contents written before the mismatch stay written.
- Undefined: no CSUM state and no XOR accumulator; LOAD goes directly to FIN.

## Structure
- Package `imem_loader_pkg`: state enum, `HDR_BYTES` = 2, `BYTES_PER_WORD` = 4, `WORD_W` = 32.
- Sub-module `word_packer`: byte-lane shift/assembly, lane counter and word-complete flag. Takes a clear input driven on `start`.
- Top level owns the FSM, word counter, address register, imem outputs and the checksum accumulator.

## Test plan
- Reset, `start`, stream 02 00 13 00 00 00 93 00 10 00 → writes addr 0 = 0x00000013 and addr 1 = 0x00100093. `done` = 1, `core_hold` = 0 two cycles after the last byte.
- Header 00 00 → `error` = 1, `core_hold` = 1, `byte_ready` = 0, no `imem_we`. Then `start` plus a valid image → DONE.
- `ADDR_W` = 4, header 11 00 (17) → ERROR. Header 10 00 with 64 bytes → last write at addr 15, then DONE.
- `byte_valid` asserted every third cycle → same writes and data as back-to-back. `imem_we` pulses exactly once per word.
- Assert `reset` after 6 payload bytes of a 2-word image → all outputs 0 immediately. Exactly one `imem_we` seen (addr 0), none after.
- Macro defined: correct XOR byte → DONE. Wrong byte → `error` = 1, `done` = 0, `core_hold` = 1.
